// File: rtl/hf4137_4_2_encoder_queue_if.sv
// ---------------------------------------------------------------------------
// hf4137_4_2_encoder_queue_if
// Groups the request-side pins and the code valid/ready drain port of the
// 4-to-2 encoder queue.
//   slave  : the encoder queue (takes req_n/en_n/code_ready, drives the rest)
//   master : whoever drives the request lines and consumes codes
//   req_n[3:0]  active-low requests (async)   en_n        active-low enable (async)
//   code_out    head code, 0 when empty       code_valid  FIFO non-empty
//   code_ready  consumer accepts head         gs_n        registered group select
//   overflow    sticky dropped-edge flag      fifo_count  FIFO occupancy
// ---------------------------------------------------------------------------
interface hf4137_4_2_encoder_queue_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [3:0]                    req_n;
    logic                          en_n;
    logic [1:0]                    code_out;
    logic                          code_valid;
    logic                          code_ready;
    logic                          gs_n;
    logic                          overflow;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport slave (
        input  req_n, en_n, code_ready,
        output code_out, code_valid, gs_n, overflow, fifo_count
    );

    modport master (
        output req_n, en_n, code_ready,
        input  code_out, code_valid, gs_n, overflow, fifo_count
    );
endinterface

// File: rtl/hf4137_4_2_encoder_queue.sv
// ---------------------------------------------------------------------------
// hf4137_4_2_encoder_queue
// Synchronizes four active-low request lines and an active-low enable,
// turns each falling edge into a pending event, picks the highest pending
// index each cycle and queues its 2-bit code in a first-word-fall-through
// FIFO drained over a valid/ready port.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave side of hf4137_4_2_encoder_queue_if (requests, enable,
//          code/valid/ready, gs_n, overflow, fifo_count)
// ---------------------------------------------------------------------------
module hf4137_4_2_encoder_queue #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    hf4137_4_2_encoder_queue_if.slave      bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [SYNC_STAGES-1:0][3:0] req_sync_q;
    logic [SYNC_STAGES-1:0]      en_sync_q;
    logic [3:0]                  req_prev_q;
    logic [3:0]                  pending_q, pending_d;
    logic                        gs_n_q, gs_n_d;
    logic                        overflow_q, overflow_d;
    logic [FIFO_DEPTH-1:0][1:0]  mem_q;
    logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]               count_q, count_d;

    logic [3:0] req_s;
    logic       en_s;
    logic [3:0] fall;
    logic [3:0] clr;
    logic [1:0] push_idx;
    logic       push, pop;

    assign req_s = req_sync_q[SYNC_STAGES-1];
    assign en_s  = en_sync_q[SYNC_STAGES-1];

    // Falling edge of a synced request, only honoured while enabled; edges
    // seen while disabled are simply lost.
    assign fall = req_prev_q & ~req_s & {4{~en_s}};

    // Fixed priority: highest set pending index wins.
    always_comb begin
        push_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pending_q[i]) push_idx = 2'(i);
        end
    end

    assign pop  = (count_q != '0) & bus.code_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    // Nothing is pushed while disabled: pending is being flushed.
    assign push = (pending_q != 4'b0000) & ~en_s &
                  ((count_q != CW'(FIFO_DEPTH)) | pop);
    assign clr  = push ? (4'b0001 << push_idx) : 4'b0000;

    always_comb begin
        pending_d  = en_s ? 4'b0000 : ((pending_q & ~clr) | fall);
        // A fresh edge on a bit that stays pending merges and is counted as
        // lost; a bit being pushed this cycle just re-arms instead.
        overflow_d = overflow_q | (|(fall & pending_q & ~clr));
        gs_n_d     = ~(~en_s & (req_s != 4'b1111));
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_sync_q <= '1;
            en_sync_q  <= '1;
            req_prev_q <= 4'b1111;
            pending_q  <= 4'b0000;
            gs_n_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1) begin
                req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], bus.req_n};
                en_sync_q  <= {en_sync_q[SYNC_STAGES-2:0], bus.en_n};
            end
            req_prev_q <= req_s;
            pending_q  <= pending_d;
            gs_n_q     <= gs_n_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_idx;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    assign bus.code_valid = (count_q != '0);
    assign bus.code_out   = bus.code_valid ? mem_q[rd_ptr_q] : 2'b00;
    assign bus.gs_n       = gs_n_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_hf4137_4_2_encoder_queue.sv
module tb_hf4137_4_2_encoder_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [1:0] sb_q[$];

    hf4137_4_2_encoder_queue_if #(.FIFO_DEPTH(4)) bus ();

    hf4137_4_2_encoder_queue #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " code_valid"}, int'(bus.code_valid), 0);
        chk({tag, " code_out"},   int'(bus.code_out),   0);
        chk({tag, " fifo_count"}, int'(bus.fifo_count), 0);
        chk({tag, " gs_n"},       int'(bus.gs_n),       1);
        chk({tag, " overflow"},   int'(bus.overflow),   0);
    endtask

    // Scoreboard side: a pop happens at the next rising edge whenever
    // valid & ready are seen here; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (!rst && bus.code_valid && bus.code_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_code: got %0d expected none", bus.code_out);
            end else begin
                logic [1:0] e;
                e = sb_q.pop_front();
                n_cmp++;
                assert (bus.code_out === e) else begin
                    n_err++;
                    $error("FAIL code_order: got %0d expected %0d", bus.code_out, e);
                end
            end
        end
    end

    initial begin
        bus.req_n      = 4'b1111;
        bus.en_n       = 1'b0;
        bus.code_ready = 1'b0;
        tick(3);
        chk_reset("reset");
        rst = 1'b0;
        tick(4);

        // Single request, exact latency
        bus.req_n = 4'b1101;
        sb_q.push_back(2'd1);
        tick(3);
        chk("lat early valid", int'(bus.code_valid), 0);
        tick(1);
        chk("lat valid",  int'(bus.code_valid), 1);
        chk("lat code",   int'(bus.code_out),   1);
        chk("lat count",  int'(bus.fifo_count), 1);
        chk("lat gs_n",   int'(bus.gs_n),       0);
        tick(5);
        chk("hold code", int'(bus.code_out), 1);
        bus.code_ready = 1'b1;
        tick(1);
        bus.code_ready = 1'b0;
        chk("pop valid", int'(bus.code_valid), 0);
        chk("pop count", int'(bus.fifo_count), 0);
        bus.req_n = 4'b1111;
        tick(4);

        // Simultaneous falls, drained in priority order
        bus.code_ready = 1'b1;
        bus.req_n = 4'b0000;
        sb_q.push_back(2'd3); sb_q.push_back(2'd2);
        sb_q.push_back(2'd1); sb_q.push_back(2'd0);
        tick(12);
        chk("all4 count", int'(bus.fifo_count), 0);
        chk("all4 overflow", int'(bus.overflow), 0);
        bus.req_n = 4'b1111;
        tick(4);

        // Six events with the FIFO blocked: four queued, two wait pending
        bus.code_ready = 1'b0;
        bus.req_n = 4'b1110; sb_q.push_back(2'd0); tick(5);
        bus.req_n = 4'b1100; sb_q.push_back(2'd1); tick(5);
        bus.req_n = 4'b1000; sb_q.push_back(2'd2); tick(5);
        bus.req_n = 4'b0000; sb_q.push_back(2'd3); tick(5);
        bus.req_n = 4'b1111; tick(4);
        bus.req_n = 4'b1100; sb_q.push_back(2'd1); sb_q.push_back(2'd0);
        tick(6);
        chk("full count", int'(bus.fifo_count), 4);
        chk("full gs_n",  int'(bus.gs_n),       0);
        bus.code_ready = 1'b1;
        tick(14);
        chk("six drained", int'(bus.fifo_count), 0);
        chk("six overflow", int'(bus.overflow), 0);
        bus.req_n = 4'b1111;
        tick(4);

        // Overflow: second edge on a bit still pending behind a full FIFO
        bus.code_ready = 1'b0;
        bus.req_n = 4'b0000;
        sb_q.push_back(2'd3); sb_q.push_back(2'd2);
        sb_q.push_back(2'd1); sb_q.push_back(2'd0);
        tick(8);
        bus.req_n = 4'b1111; tick(4);
        bus.req_n = 4'b1011; sb_q.push_back(2'd2); tick(5);
        chk("ovf before", int'(bus.overflow), 0);
        bus.req_n = 4'b1111; tick(4);
        bus.req_n = 4'b1011; tick(5);
        chk("ovf set", int'(bus.overflow), 1);
        bus.code_ready = 1'b1;
        tick(14);
        chk("ovf sticky", int'(bus.overflow), 1);
        chk("ovf drained", int'(bus.fifo_count), 0);
        bus.req_n = 4'b1111;
        tick(4);
        rst = 1'b1; tick(1);
        rst = 1'b0; tick(1);
        chk("ovf rst", int'(bus.overflow), 0);

        // Disabled requests are ignored
        bus.en_n = 1'b1;
        tick(3);
        bus.req_n = 4'b1110; tick(4);
        chk("dis gs_n", int'(bus.gs_n), 1);
        bus.req_n = 4'b1111; tick(4);
        chk("dis count", int'(bus.fifo_count), 0);
        chk("dis valid", int'(bus.code_valid), 0);

        // Pending flushed by disable, queued codes kept
        bus.en_n = 1'b0;
        bus.code_ready = 1'b0;
        tick(3);
        bus.req_n = 4'b0000;
        sb_q.push_back(2'd3); sb_q.push_back(2'd2);
        sb_q.push_back(2'd1); sb_q.push_back(2'd0);
        tick(8);
        bus.req_n = 4'b1111; tick(4);
        bus.req_n = 4'b1110; tick(3);
        bus.en_n = 1'b1; tick(4);
        bus.code_ready = 1'b1;
        tick(10);
        chk("flush count", int'(bus.fifo_count), 0);
        bus.en_n = 1'b0; tick(6);
        chk("flush nothing new", int'(bus.code_valid), 0);
        bus.req_n = 4'b1111;
        tick(4);

        // Asynchronous reset with three codes queued
        bus.code_ready = 1'b0;
        bus.req_n = 4'b0001;
        tick(8);
        chk("pre-rst count", int'(bus.fifo_count), 3);
        #2;
        rst = 1'b1;
        bus.req_n = 4'b1111;
        #1;
        chk_reset("async rst");
        tick(2);
        rst = 1'b0;
        bus.code_ready = 1'b1;
        tick(10);
        chk("post-rst valid", int'(bus.code_valid), 0);
        chk("post-rst count", int'(bus.fifo_count), 0);
        chk("scoreboard empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
